prim_rr_onehot_arb: RTL and testbench
=====================================

Name: prim_rr_onehot_arb

Overview:
Round-robin arbiter that shares one Width-bit one-hot AND/OR mux between Inputs requesters using a valid/ready handshake. It produces a one-hot-or-zero select, the muxed data, the winner index and per-requester grants. The grant is held stable while the downstream is stalled. Used wherever several ibex/prim producers feed one consumer port.

Parameters:
Width, 32, data width per requester
Inputs, 8, number of requesters (>=2)
IdxW, $clog2(Inputs), derived (localparam), width of idx_o

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
req_i  in  Inputs  per-requester valid; must stay high with stable data until its gnt_o
data_i  in  Width x Inputs (unpacked [Inputs])  per-requester payload
last_i  in  Inputs  end-of-packet marker per requester (present only with RR_ARB_PKT_LOCK_EN)
gnt_o  out  Inputs  one-hot-or-zero; gnt_o[i] = sel_o[i] & valid_o & ready_i (transfer accepted)
sel_o  out  Inputs  one-hot-or-zero mux select
valid_o  out  1  output payload valid
data_o  out  Width  payload of selected requester
idx_o  out  IdxW  binary index of selected requester
ready_i  in  1  downstream ready

Behaviour:
- Reset (rst_i high, async): ptr_q=0, sel_q=0, state=ARB. While rst_i is high, valid_o, gnt_o and sel_o are forced to 0, data_o=0 and idx_o=0.
- FSM states: ARB and HOLD.
- ARB state:
  - sel_o = first set req_i bit searching upward from ptr_q, wrapping Inputs-1 -> 0.
  - All zero -> sel_o=0, valid_o=0.
  - Zero latency: sel_o, valid_o, data_o and idx_o are combinational in the same cycle as req_i.
- ARB transitions:
  - valid_o & ready_i -> transfer; ptr_q <= (winner+1) mod Inputs; stay ARB.
  - valid_o & !ready_i -> sel_q <= sel_o; go HOLD.
- HOLD state:
  - sel_o = sel_q; new requests cannot change the grant; valid_o = |(sel_q & req_i).
  - ready_i high with valid_o -> transfer, ptr advance, back to ARB.
- Protocol violation: the held requester drops req in HOLD. valid_o goes low that cycle, state returns to ARB, ptr_q is unchanged. An assertion flags it.
- data_o = OR over i of (data_i[i] & {Width{sel_o[i]}}). Zero when sel_o=0.
- idx_o = encoded sel_o; 0 when sel_o=0.
- Fairness: a continuously requesting input is served within Inputs transfers.
- ptr wrap: ptr_q = Inputs-1 and winner Inputs-1 -> ptr_q=0. Arithmetic is mod Inputs for non-power-of-2 Inputs.
- Same-cycle request arrival during an accept: it is seen by the next cycle's arbitration only.
- Assertions: sel_o onehot0; gnt_o implies req_i; data_o stable while valid_o & !ready_i.

Optional Feature:
- RR_ARB_PKT_LOCK_EN defined:
  - Adds last_i port and a lock_q flag.
  - After an accepted beat with last_i[winner]=0, grant stays on the winner (lock_q=1, ptr not advanced) until an accepted beat with last_i=1.
  - Then ptr advances and lock clears.
  - Reset clears lock.
- Undefined: no last_i port; every beat is an independent arbitration.

Decomposition:
- prim_rr_arb_pkg holds:
  - arb_state_e enum {ArbIdle=ARB, ArbHold=HOLD}
  - a function computing the rotating-priority one-hot pick from (req, ptr)
  - a function for onehot-to-index encoding
- Data path instantiates the existing prim_onehot_mux (Width, Inputs) as the single sub-module, driven by sel_o.

Test Plan:
(Width=8, Inputs=4)
1. Reset: rst_i=1, req_i=4'b1111 -> valid_o=0, sel_o=0, gnt_o=0; release, ready_i=1 -> sel_o=0001, data_o=data_i[0].
2. Rotation: req_i=1111, ready_i=1 for 5 cycles -> grants 0,1,2,3,0; idx_o 0,1,2,3,0.
3. Stall hold: req_i=0010, ready_i=0 for 3 cycles, req_i[0] raised in cycle 2 -> sel_o stays 0010, data_o=0xA5 stable; ready_i=1 -> gnt_o=0010, next sel_o=0001.
4. Wrap with gaps: ptr=3, req_i=0101 -> sel_o=0001; after accept, ptr=1 -> sel_o=0100.
5. Violation: HOLD on input 2, req_i[2] dropped -> valid_o=0 same cycle, assertion fires, ptr unchanged.
6. RR_ARB_PKT_LOCK_EN: req_i=0011, input 0 sends 3 beats with last_i[0]=0,0,1 -> gnt_o=0001 three times, then 0010.

Source files
------------

// File: rtl/prim_rr_onehot_arb_pkg.sv
// Shared types and helpers for the round-robin one-hot arbiter.
// The RR_ARB_PKT_LOCK_EN build option is handled in the top and interface files.
package prim_rr_arb_pkg;

  // Helper functions work on a fixed maximum vector; callers size-cast the result.
  localparam int unsigned MaxInputs = 32;
  localparam int unsigned MaxIdxW   = 5;

  typedef enum logic {
    ArbIdle = 1'b0,
    ArbHold = 1'b1
  } arb_state_e;

  // One-hot pick of the first set req bit at or above ptr, wrapping at n.
  function automatic logic [MaxInputs-1:0] rr_pick(input logic [MaxInputs-1:0] req,
                                                   input int unsigned ptr,
                                                   input int unsigned n);
    logic [MaxInputs-1:0] pick;
    logic [MaxIdxW-1:0]   idx;
    logic                 found;
    pick  = '0;
    found = 1'b0;
    for (int unsigned off = 0; off < MaxInputs; off++) begin
      if (off < n) begin
        if (ptr + off >= n) idx = MaxIdxW'(ptr + off - n);
        else                idx = MaxIdxW'(ptr + off);
        if (!found && req[idx]) begin
          pick[idx] = 1'b1;
          found     = 1'b1;
        end
      end
    end
    return pick;
  endfunction

  function automatic logic [MaxIdxW-1:0] oh_to_idx(input logic [MaxInputs-1:0] oh);
    logic [MaxIdxW-1:0] idx;
    idx = '0;
    for (int i = 0; i < MaxInputs; i++) begin
      if (oh[i]) idx = idx | MaxIdxW'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/prim_rr_onehot_arb_if.sv
// Requester/consumer bundle of the round-robin arbiter; last_i exists only
// when RR_ARB_PKT_LOCK_EN is defined.
interface prim_rr_onehot_arb_if
  import prim_rr_arb_pkg::*;
#(
  parameter int unsigned Width  = 32,
  parameter int unsigned Inputs = 8
);
  localparam int unsigned IdxW = $clog2(Inputs);

  // Handshake: requester i holds req_i[i] and data_i[i] stable until gnt_o[i];
  // a beat moves downstream in the cycle where valid_o & ready_i are both high.
  logic [Inputs-1:0] req_i;
  logic [Width-1:0]  data_i [Inputs];
`ifdef RR_ARB_PKT_LOCK_EN
  logic [Inputs-1:0] last_i;
`endif
  logic [Inputs-1:0] gnt_o;
  logic [Inputs-1:0] sel_o;
  logic              valid_o;
  logic [Width-1:0]  data_o;
  logic [IdxW-1:0]   idx_o;
  logic              ready_i;
  arb_state_e        state_o;

`ifdef RR_ARB_PKT_LOCK_EN
  modport slave  (input  req_i, data_i, last_i, ready_i,
                  output gnt_o, sel_o, valid_o, data_o, idx_o, state_o);
  modport master (output req_i, data_i, last_i, ready_i,
                  input  gnt_o, sel_o, valid_o, data_o, idx_o, state_o);
`else
  modport slave  (input  req_i, data_i, ready_i,
                  output gnt_o, sel_o, valid_o, data_o, idx_o, state_o);
  modport master (output req_i, data_i, ready_i,
                  input  gnt_o, sel_o, valid_o, data_o, idx_o, state_o);
`endif

endinterface

// File: rtl/prim_rr_onehot_arb_mux.sv
// AND/OR one-hot multiplexer; output is zero when no select bit is set.
module prim_onehot_mux #(
  parameter int unsigned Width  = 32,
  parameter int unsigned Inputs = 8
) (
  input  logic [Width-1:0]  in_i [Inputs],
  input  logic [Inputs-1:0] sel_i,
  output logic [Width-1:0]  out_o
);

  always_comb begin
    out_o = '0;
    for (int i = 0; i < Inputs; i++) begin
      out_o = out_o | (in_i[i] & {Width{sel_i[i]}});
    end
  end

endmodule

// File: rtl/prim_rr_onehot_arb.sv
// Round-robin arbiter sharing one one-hot mux; grant is frozen while stalled.
// Define RR_ARB_PKT_LOCK_EN to keep the grant on a requester until its last_i beat.
module prim_rr_onehot_arb
  import prim_rr_arb_pkg::*;
#(
  parameter int unsigned Width  = 32,
  parameter int unsigned Inputs = 8
) (
  input logic                 clk_i,
  input logic                 rst_i,
  prim_rr_onehot_arb_if.slave bus
);

  localparam int unsigned IdxW = $clog2(Inputs);

  arb_state_e        state_q, state_d;
  logic [Inputs-1:0] sel_q, sel_d, pick, sel;
  logic [IdxW-1:0]   ptr_q, ptr_d, win_idx, ptr_inc;
  logic              valid, xfer, locked;

  assign pick    = Inputs'(rr_pick(MaxInputs'(bus.req_i), 32'(ptr_q), Inputs));
  assign win_idx = IdxW'(oh_to_idx(MaxInputs'(sel)));
  assign ptr_inc = (win_idx == IdxW'(Inputs - 1)) ? '0 : win_idx + 1'b1;
  assign xfer    = valid & bus.ready_i;

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ArbIdle;
      sel_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
    end
  end

  // Next state: a stalled beat parks in HOLD; a transfer or a dropped request leaves it.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ArbIdle: if (valid && !bus.ready_i) state_d = ArbHold;
      ArbHold: if (!valid || bus.ready_i) state_d = ArbIdle;
      default: state_d = ArbIdle;
    endcase
  end

  // Outputs: everything is forced quiet while reset is asserted.
  always_comb begin
    sel   = '0;
    valid = 1'b0;
    if (!rst_i) begin
      sel   = (state_q == ArbHold || locked) ? sel_q : pick;
      valid = |(sel & bus.req_i);
    end
  end

`ifdef RR_ARB_PKT_LOCK_EN
  logic lock_q, lock_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) lock_q <= 1'b0;
    else       lock_q <= lock_d;
  end

  assign locked = lock_q;

  // Pointer only moves past a requester once its packet's last beat is accepted.
  always_comb begin
    sel_d  = valid ? sel : sel_q;
    ptr_d  = ptr_q;
    lock_d = lock_q;
    if (xfer) begin
      if (|(sel & bus.last_i)) begin
        ptr_d  = ptr_inc;
        lock_d = 1'b0;
      end else begin
        lock_d = 1'b1;
      end
    end
  end
`else
  assign locked = 1'b0;

  always_comb begin
    sel_d = valid ? sel : sel_q;
    ptr_d = xfer ? ptr_inc : ptr_q;
  end
`endif

  prim_onehot_mux #(
    .Width  (Width),
    .Inputs (Inputs)
  ) u_mux (
    .in_i  (bus.data_i),
    .sel_i (sel),
    .out_o (bus.data_o)
  );

  assign bus.sel_o   = sel;
  assign bus.valid_o = valid;
  assign bus.gnt_o   = sel & {Inputs{xfer}};
  assign bus.idx_o   = win_idx;
  assign bus.state_o = state_q;

  sel_onehot0_a: assert property (@(posedge clk_i) disable iff (rst_i)
    $onehot0(bus.sel_o));
  gnt_has_req_a: assert property (@(posedge clk_i) disable iff (rst_i)
    (bus.gnt_o & ~bus.req_i) == '0);
  data_stable_a: assert property (@(posedge clk_i) disable iff (rst_i)
    (bus.valid_o && !bus.ready_i) |=> $stable(bus.data_o));
  // A held requester withdrawing before its grant breaks the input protocol.
  held_req_a: assert property (@(posedge clk_i) disable iff (rst_i)
    (state_q == ArbHold) |-> |(sel_q & bus.req_i))
    else $warning("requester %0d withdrew its request while held", win_idx);

endmodule

// File: tb/tb_prim_rr_onehot_arb.sv
// Vector-table bench for prim_rr_onehot_arb (Width=8, Inputs=4); the
// packet-lock sequence is included when RR_ARB_PKT_LOCK_EN is defined.
module tb_prim_rr_onehot_arb;

  localparam int unsigned W  = 8;
  localparam int unsigned N  = 4;
  localparam int unsigned IW = $clog2(N);
  localparam int unsigned OW = N + 1 + N + IW + W;

  typedef struct {
    logic [N-1:0]  req;
    logic [N-1:0]  last;
    logic          ready;
    logic [N-1:0]  sel;
    logic          valid;
    logic [N-1:0]  gnt;
    logic [IW-1:0] idx;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  data_vals [N];
  logic [OW-1:0] exp_q [$];
  int            n_vec = 0;
  int            n_err = 0;
  vec_t          tbl [20];

  // clock/reset block
  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("FAIL watchdog: time limit reached, vectors=%0d", n_vec);
    $fatal(1, "watchdog");
  end

  prim_rr_onehot_arb_if #(.Width(W), .Inputs(N)) bus ();

  prim_rr_onehot_arb #(.Width(W), .Inputs(N)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  function automatic vec_t mk(input logic [N-1:0] req, input logic ready,
                              input logic [N-1:0] sel, input logic valid,
                              input logic [N-1:0] gnt, input logic [IW-1:0] idx,
                              input logic [N-1:0] last = '1);
    vec_t v;
    v.req = req; v.ready = ready; v.sel = sel; v.valid = valid;
    v.gnt = gnt; v.idx = idx; v.last = last;
    return v;
  endfunction

  function automatic logic [W-1:0] model_data(input logic [N-1:0] sel);
    logic [W-1:0] d;
    d = '0;
    for (int i = 0; i < N; i++) if (sel[i]) d = d | data_vals[i];
    return d;
  endfunction

  // scoreboard
  task automatic check_out(input string name);
    logic [OW-1:0] exp_v, act_v;
    act_v = {bus.sel_o, bus.valid_o, bus.gnt_o, bus.idx_o, bus.data_o};
    n_vec++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL %s: output %h appeared with no expected entry queued", name, act_v);
    end else begin
      exp_v = exp_q.pop_front();
      if (act_v !== exp_v) begin
        n_err++;
        $display("FAIL %s: got sel=%b valid=%b gnt=%b idx=%0d data=%h, need sel=%b valid=%b gnt=%b idx=%0d data=%h",
                 name, act_v[OW-1 -: N], act_v[OW-N-1], act_v[OW-N-2 -: N], act_v[W+IW-1 -: IW], act_v[W-1:0],
                 exp_v[OW-1 -: N], exp_v[OW-N-1], exp_v[OW-N-2 -: N], exp_v[W+IW-1 -: IW], exp_v[W-1:0]);
      end
    end
  endtask

  // driver: inputs change just after the rising edge, outputs sampled on the falling edge
  task automatic apply(input vec_t v, input string name);
    @(posedge clk);
    #1;
    bus.req_i   = v.req;
    bus.ready_i = v.ready;
`ifdef RR_ARB_PKT_LOCK_EN
    bus.last_i  = v.last;
`endif
    exp_q.push_back({v.sel, v.valid, v.gnt, v.idx, model_data(v.sel)});
    @(negedge clk);
    check_out(name);
  endtask

  initial begin
    data_vals[0] = 8'($urandom_range(8'h00, 8'h3F));
    data_vals[1] = 8'hA5;
    data_vals[2] = 8'($urandom_range(8'h40, 8'h7F));
    data_vals[3] = 8'($urandom_range(8'hC0, 8'hFF));
    for (int i = 0; i < N; i++) bus.data_i[i] = data_vals[i];
    rst         = 1'b1;
    bus.req_i   = 4'b1111;
    bus.ready_i = 1'b1;
`ifdef RR_ARB_PKT_LOCK_EN
    bus.last_i  = '1;
`endif

    //           req      rdy   sel      vld   gnt      idx
    tbl[0]  = mk(4'b1111, 1'b1, 4'b0001, 1'b1, 4'b0001, 2'd0);
    tbl[1]  = mk(4'b1111, 1'b1, 4'b0010, 1'b1, 4'b0010, 2'd1);
    tbl[2]  = mk(4'b1111, 1'b1, 4'b0100, 1'b1, 4'b0100, 2'd2);
    tbl[3]  = mk(4'b1111, 1'b1, 4'b1000, 1'b1, 4'b1000, 2'd3);
    tbl[4]  = mk(4'b1111, 1'b1, 4'b0001, 1'b1, 4'b0001, 2'd0);
    tbl[5]  = mk(4'b0010, 1'b0, 4'b0010, 1'b1, 4'b0000, 2'd1);
    tbl[6]  = mk(4'b0011, 1'b0, 4'b0010, 1'b1, 4'b0000, 2'd1);
    tbl[7]  = mk(4'b0011, 1'b0, 4'b0010, 1'b1, 4'b0000, 2'd1);
    tbl[8]  = mk(4'b0011, 1'b1, 4'b0010, 1'b1, 4'b0010, 2'd1);
    tbl[9]  = mk(4'b0011, 1'b0, 4'b0001, 1'b1, 4'b0000, 2'd0);
    tbl[10] = mk(4'b0001, 1'b1, 4'b0001, 1'b1, 4'b0001, 2'd0);
    tbl[11] = mk(4'b0100, 1'b1, 4'b0100, 1'b1, 4'b0100, 2'd2);
    tbl[12] = mk(4'b0101, 1'b1, 4'b0001, 1'b1, 4'b0001, 2'd0);
    tbl[13] = mk(4'b0101, 1'b1, 4'b0100, 1'b1, 4'b0100, 2'd2);
    tbl[14] = mk(4'b1001, 1'b1, 4'b1000, 1'b1, 4'b1000, 2'd3);
    tbl[15] = mk(4'b1001, 1'b1, 4'b0001, 1'b1, 4'b0001, 2'd0);
    tbl[16] = mk(4'b0000, 1'b1, 4'b0000, 1'b0, 4'b0000, 2'd0);
    tbl[17] = mk(4'b1000, 1'b0, 4'b1000, 1'b1, 4'b0000, 2'd3);
    tbl[18] = mk(4'b1111, 1'b1, 4'b1000, 1'b1, 4'b1000, 2'd3);
    tbl[19] = mk(4'b0110, 1'b1, 4'b0010, 1'b1, 4'b0010, 2'd1);

    // reset holds every output at zero even with all requests raised
    apply(mk(4'b1111, 1'b1, 4'b0000, 1'b0, 4'b0000, 2'd0), "reset_quiet");
    bus.req_i = '0;
    rst       = 1'b0;

    for (int i = 0; i < 20; i++) apply(tbl[i], $sformatf("tbl_%0d", i));

    // held requester 2 withdraws: valid drops at once, pointer stays on 2
    apply(mk(4'b0100, 1'b0, 4'b0100, 1'b1, 4'b0000, 2'd2), "viol_hold");
    apply(mk(4'b1011, 1'b1, 4'b0100, 1'b0, 4'b0000, 2'd2), "viol_drop");
    apply(mk(4'b1111, 1'b1, 4'b0100, 1'b1, 4'b0100, 2'd2), "viol_ptr_kept");

`ifdef RR_ARB_PKT_LOCK_EN
    // three-beat packet from requester 0 keeps the grant, then requester 1 is served
    apply(mk(4'b0011, 1'b1, 4'b0001, 1'b1, 4'b0001, 2'd0, 4'b0000), "lock_beat0");
    apply(mk(4'b0011, 1'b1, 4'b0001, 1'b1, 4'b0001, 2'd0, 4'b0000), "lock_beat1");
    apply(mk(4'b0011, 1'b1, 4'b0001, 1'b1, 4'b0001, 2'd0, 4'b0001), "lock_last");
    apply(mk(4'b0011, 1'b1, 4'b0010, 1'b1, 4'b0010, 2'd1, 4'b1111), "lock_released");
`endif

    // asynchronous reset mid-cycle quiets outputs and returns the pointer to 0
    @(posedge clk);
    #2;
    bus.req_i   = 4'b1111;
    bus.ready_i = 1'b1;
    rst         = 1'b1;
    #1;
    exp_q.push_back('0);
    check_out("async_reset");
    bus.req_i = '0;
    rst       = 1'b0;
    apply(mk(4'b1111, 1'b1, 4'b0001, 1'b1, 4'b0001, 2'd0), "post_reset_ptr");

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
